vehicle_data_receiver: RTL

Receive-side counterpart of the vehicle data generator. It consumes received CAN frames from the CAN controller's receive stream and decodes the two vehicle-data IDs into registered engine revolution, vehicle speed and battery values. It tracks per-ID freshness with timeout watchdogs and counts malformed frames. It sits between the CAN controller receive port and any dashboard or logging logic on a second node.

---
 rtl/vehicle_data_pkg.sv | 39 +++
 rtl/vehicle_data_receiver_stale_watchdog.sv | 26 ++
 rtl/vehicle_data_receiver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vehicle_data_pkg.sv
// vehicle_data_pkg: constants and types shared by the vehicle data generator
// and receiver. Holds the default frame IDs, the frame-class enum, the
// receiver FSM state enum and the frame classifier.
package vehicle_data_pkg;

  localparam logic [10:0] ID_ENGINE_REV_DFLT = 11'h3D9;
  localparam logic [10:0] ID_CAR_SPEED_DFLT  = 11'h3E9;

  typedef enum logic [1:0] {
    FRAME_ENGINE,
    FRAME_SPEED,
    FRAME_UNKNOWN,
    FRAME_BAD
  } frame_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_UPDATE
  } rx_state_e;

  // A known ID is BAD when a required byte is missing or the high byte
  // carries bits outside the field width.
  function automatic frame_class_e classify(
    input logic [10:0] tid,
    input logic [2:0]  keep,
    input logic [7:0]  b0,
    input logic [10:0] id_eng,
    input logic [10:0] id_spd
  );
    if (tid == id_eng)
      return (keep[1:0] == 2'b11 && b0[7:6] == 2'b00) ? FRAME_ENGINE : FRAME_BAD;
    else if (tid == id_spd)
      return (keep[2:0] == 3'b111 && b0[7:1] == 7'd0) ? FRAME_SPEED : FRAME_BAD;
    else
      return FRAME_UNKNOWN;
  endfunction

endpackage

// File: rtl/vehicle_data_receiver_stale_watchdog.sv
// stale_watchdog: saturating freshness counter for one frame ID.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : restart the count (wins over saturation)
//   o_stale    : high while the counter sits at TIMEOUT
// Resets to TIMEOUT so the ID reads stale until its first valid frame.
module stale_watchdog #(
  parameter int TIMEOUT = 100
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_stale
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAXV = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= MAXV;
    else if (i_clear)        r_cnt <= '0;
    else if (r_cnt != MAXV)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_stale = (r_cnt == MAXV);
endmodule

// File: rtl/vehicle_data_receiver.sv
// vehicle_data_receiver: decodes engine-rev and speed/battery CAN frames
// from the controller receive stream into registered outputs.
//   clk, rst_n              : clock, async active-low reset
//   stm_recv_data_in_*      : receive stream (tdata/tid/tkeep/tvalid in, tready out)
//   engine_rev, vehicle_speed, battery_value : last decoded values
//   engine_rev_update, speed_update          : one-cycle write pulses
//   engine_rev_stale, speed_stale            : per-ID timeout flags
//   error_count                              : saturating malformed-frame count
// One frame per 3 cycles: IDLE (accept) -> CHECK (classify) -> UPDATE (write).
module vehicle_data_receiver
  import vehicle_data_pkg::*;
#(
  parameter int          CLK_FREQ_HZ   = 50_000_000,
  parameter int          TIMEOUT_CYCLE = CLK_FREQ_HZ / 10,
  parameter logic [10:0] ID_ENGINE_REV = ID_ENGINE_REV_DFLT,
  parameter logic [10:0] ID_CAR_SPEED  = ID_CAR_SPEED_DFLT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] stm_recv_data_in_tdata,
  input  logic [10:0] stm_recv_data_in_tid,
  input  logic [7:0]  stm_recv_data_in_tkeep,
  input  logic        stm_recv_data_in_tvalid,
  output logic        stm_recv_data_in_tready,
  output logic [13:0] engine_rev,
  output logic [8:0]  vehicle_speed,
  output logic [7:0]  battery_value,
  output logic        engine_rev_update,
  output logic        speed_update,
  output logic        engine_rev_stale,
  output logic        speed_stale,
  output logic [7:0]  error_count
);
  rx_state_e    r_state;
  frame_class_e r_class;
  logic         r_tready;
  logic [10:0]  r_tid;
  logic [2:0]   r_keep;
  logic [7:0]   r_b0, r_b1, r_b2;
  logic [13:0]  r_rev;
  logic [8:0]   r_spd;
  logic [7:0]   r_bat, r_err;
  logic         r_rev_upd, r_spd_upd;
  frame_class_e w_class;
  logic         w_eng_clr, w_spd_clr;

  // Bytes 3..7 and their keep bits never influence decoding.
  logic w_unused_bits;
  assign w_unused_bits = ^{stm_recv_data_in_tdata[63:24], stm_recv_data_in_tkeep[7:3]};

  assign w_class = classify(r_tid, r_keep, r_b0, ID_ENGINE_REV, ID_CAR_SPEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_class   <= FRAME_UNKNOWN;
      r_tready  <= 1'b0;
      r_tid     <= '0;
      r_keep    <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_b2      <= '0;
      r_rev     <= '0;
      r_spd     <= '0;
      r_bat     <= '0;
      r_err     <= '0;
      r_rev_upd <= 1'b0;
      r_spd_upd <= 1'b0;
    end else begin
      r_rev_upd <= 1'b0;
      r_spd_upd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (stm_recv_data_in_tvalid && r_tready) begin
            r_tid    <= stm_recv_data_in_tid;
            r_keep   <= stm_recv_data_in_tkeep[2:0];
            r_b0     <= stm_recv_data_in_tdata[7:0];
            r_b1     <= stm_recv_data_in_tdata[15:8];
            r_b2     <= stm_recv_data_in_tdata[23:16];
            r_tready <= 1'b0;
            r_state  <= ST_CHECK;
          end else begin
            r_tready <= 1'b1;
          end
        end
        ST_CHECK: begin
          r_class <= w_class;
          if (w_class == FRAME_ENGINE || w_class == FRAME_SPEED) begin
            r_state <= ST_UPDATE;
          end else begin
            if (w_class == FRAME_BAD && r_err != 8'hFF) r_err <= r_err + 8'd1;
            r_tready <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          if (r_class == FRAME_ENGINE) begin
            r_rev     <= {r_b0[5:0], r_b1};
            r_rev_upd <= 1'b1;
          end else begin
            r_spd     <= {r_b0[0], r_b1};
            r_bat     <= r_b2;
            r_spd_upd <= 1'b1;
          end
          r_tready <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_tready <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_eng_clr = (r_state == ST_UPDATE) && (r_class == FRAME_ENGINE);
  assign w_spd_clr = (r_state == ST_UPDATE) && (r_class == FRAME_SPEED);

  stale_watchdog #(.TIMEOUT(TIMEOUT_CYCLE)) u_wd_eng (
    .clk(clk), .rst_n(rst_n), .i_clear(w_eng_clr), .o_stale(engine_rev_stale)
  );
  stale_watchdog #(.TIMEOUT(TIMEOUT_CYCLE)) u_wd_spd (
    .clk(clk), .rst_n(rst_n), .i_clear(w_spd_clr), .o_stale(speed_stale)
  );

  assign stm_recv_data_in_tready = r_tready;
  assign engine_rev        = r_rev;
  assign vehicle_speed     = r_spd;
  assign battery_value     = r_bat;
  assign engine_rev_update = r_rev_upd;
  assign speed_update      = r_spd_upd;
  assign error_count       = r_err;
endmodule
